// File: rtl/cnn_kernel_mc.sv
// ---------------------------------------------------------------------------
// cnn_kernel_mc
// Multi-input-channel convolution kernel engine. Each accepted beat carries
// one input channel's KX*KY window of unsigned pixels plus signed weights.
// CI beats are accumulated into one output-channel result; the bias sampled
// with the last beat is added and the sum is clamped to O_BW bits.
//
// Pipeline: IN (capture + tag) -> MUL -> SUM -> ACC -> OUT
// A last beat sampled at edge E0 strobes o_ot_valid after edge E0+4.
//
// Optional feature macro: CNN_RELU_EN
//   defined   : ReLU followed by unsigned saturation to [0, 2^O_BW-1]
//   undefined : signed saturation to [-2^(O_BW-1), 2^(O_BW-1)-1]
//
// Ports:
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   i_clr        synchronous abort of partial group and in-flight beats
//   i_in_valid   beat qualifier
//   i_in_fmap    KX*KY unsigned pixels, element n at [n*I_F_BW +: I_F_BW]
//   i_cnn_weight KX*KY signed weights, same indexing
//   i_cnn_bias   signed bias, used only with the last-channel beat
//   o_busy       high while a group is partially accepted
//   o_ot_valid   one-cycle result strobe
//   o_ot_result  clamped result, held until the next strobe
// ---------------------------------------------------------------------------
module cnn_kernel_mc #(
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int CI     = 3,
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int O_BW   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_clr,
    input  logic                      i_in_valid,
    input  logic [KX*KY*I_F_BW-1:0]   i_in_fmap,
    input  logic [KX*KY*W_BW-1:0]     i_cnn_weight,
    input  logic [B_BW-1:0]           i_cnn_bias,
    output logic                      o_busy,
    output logic                      o_ot_valid,
    output logic [O_BW-1:0]           o_ot_result
);

    localparam int N      = KX * KY;
    localparam int M_BW   = I_F_BW + W_BW;
    localparam int AK_BW  = M_BW + $clog2(N);
    localparam int ACC_BW = AK_BW + $clog2(CI) + 1;
    localparam int S_BW   = ACC_BW + 1;
    localparam int CNT_BW = (CI > 1) ? $clog2(CI) : 1;

    // ---------------- channel counter / beat tagging ----------------
    logic [CNT_BW-1:0] r_ch_cnt;
    logic [CNT_BW-1:0] w_cnt_nxt;
    logic              r_busy;
    logic              w_accept;
    logic              w_first;
    logic              w_last;

    assign w_accept = i_in_valid & ~i_clr;
    assign w_first  = (r_ch_cnt == '0);
    assign w_last   = (r_ch_cnt == CNT_BW'(CI - 1));

    always_comb begin
        w_cnt_nxt = r_ch_cnt;
        if (i_clr)
            w_cnt_nxt = '0;
        else if (w_accept)
            w_cnt_nxt = w_last ? '0 : r_ch_cnt + CNT_BW'(1);
    end

    // ---------------- pipeline registers ----------------
    logic                     r_in_vld, r_in_first, r_in_last;
    logic [N*I_F_BW-1:0]      r_in_fmap;
    logic [N*W_BW-1:0]        r_in_wt;
    logic signed [B_BW-1:0]   r_in_bias;

    logic                     r_s1_vld, r_s1_first, r_s1_last;
    logic signed [M_BW-1:0]   r_prod [N];
    logic signed [B_BW-1:0]   r_s1_bias;

    logic                     r_s2_vld, r_s2_first, r_s2_last;
    logic signed [AK_BW-1:0]  r_s2_sum;
    logic signed [B_BW-1:0]   r_s2_bias;

    logic                     r_s3_fire;
    logic signed [ACC_BW-1:0] r_acc;
    logic signed [B_BW-1:0]   r_s3_bias;

    logic                     r_ot_valid;
    logic [O_BW-1:0]          r_ot_result;

    // ---------------- combinational datapath ----------------
    logic signed [M_BW-1:0]   w_prod [N];
    logic signed [AK_BW-1:0]  w_sum;
    logic signed [ACC_BW-1:0] w_sum_ext;
    logic signed [S_BW-1:0]   w_s;
    logic [O_BW-1:0]          w_clamp;

    // Pixel is zero-extended (treated as {1'b0,pixel}), weight sign-extended;
    // the M_BW-wide product cannot overflow.
    always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
            w_prod[n] = $signed(M_BW'(r_in_fmap[n*I_F_BW +: I_F_BW]))
                      * $signed(M_BW'($signed(r_in_wt[n*W_BW +: W_BW])));
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned n = 0; n < N; n++)
            w_sum = w_sum + AK_BW'(r_prod[n]);
    end

    assign w_sum_ext = ACC_BW'(r_s2_sum);
    assign w_s       = S_BW'(r_acc) + S_BW'(r_s3_bias);

`ifdef CNN_RELU_EN
    localparam logic signed [S_BW-1:0] C_MAX = S_BW'((2 ** O_BW) - 1);

    always_comb begin
        if (w_s[S_BW-1])
            w_clamp = '0;
        else if (w_s > C_MAX)
            w_clamp = '1;
        else
            w_clamp = w_s[O_BW-1:0];
    end
`else
    localparam logic signed [S_BW-1:0] C_MAX = S_BW'((2 ** (O_BW - 1)) - 1);
    localparam logic signed [S_BW-1:0] C_MIN = -C_MAX - S_BW'(1);

    always_comb begin
        if (w_s > C_MAX)
            w_clamp = C_MAX[O_BW-1:0];
        else if (w_s < C_MIN)
            w_clamp = C_MIN[O_BW-1:0];
        else
            w_clamp = w_s[O_BW-1:0];
    end
`endif

    // ---------------- control state (reset) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch_cnt    <= '0;
            r_busy      <= 1'b0;
            r_in_vld    <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s3_fire   <= 1'b0;
            r_ot_valid  <= 1'b0;
            r_ot_result <= '0;
        end else begin
            r_ch_cnt   <= w_cnt_nxt;
            r_busy     <= (w_cnt_nxt != '0);
            r_in_vld   <= w_accept;
            r_s1_vld   <= r_in_vld & ~i_clr;
            r_s2_vld   <= r_s1_vld & ~i_clr;
            r_s3_fire  <= r_s2_vld & r_s2_last & ~i_clr;
            r_ot_valid <= r_s3_fire & ~i_clr;
            if (r_s3_fire && !i_clr)
                r_ot_result <= w_clamp;
        end
    end

    // ---------------- datapath registers (no reset needed) ----------------
    // Tags travel with the data; only the valid bits above gate them, so a
    // stale tag behind a cleared valid bit is harmless.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_in_first <= w_first;
            r_in_last  <= w_last;
            r_in_fmap  <= i_in_fmap;
            r_in_wt    <= i_cnn_weight;
            r_in_bias  <= $signed(i_cnn_bias);
        end
        if (r_in_vld) begin
            r_s1_first <= r_in_first;
            r_s1_last  <= r_in_last;
            r_s1_bias  <= r_in_bias;
            for (int unsigned n = 0; n < N; n++)
                r_prod[n] <= w_prod[n];
        end
        if (r_s1_vld) begin
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_bias  <= r_s1_bias;
            r_s2_sum   <= w_sum;
        end
        // A first beat reloads acc, so back-to-back groups need no bubble.
        if (r_s2_vld) begin
            r_acc <= r_s2_first ? w_sum_ext : r_acc + w_sum_ext;
            if (r_s2_last)
                r_s3_bias <= r_s2_bias;
        end
    end

    assign o_busy      = r_busy;
    assign o_ot_valid  = r_ot_valid;
    assign o_ot_result = r_ot_result;

endmodule

// File: tb/tb_cnn_kernel_mc.sv
module tb_cnn_kernel_mc;

    localparam int N    = 25;
    localparam int FM_W = N * 8;
    localparam int WT_W = N * 8;

`ifdef CNN_RELU_EN
    localparam logic [7:0] EXP_NEG  = 8'd0;
    localparam logic [7:0] EXP_OVF  = 8'd255;
    localparam logic [7:0] EXP_BIAS = 8'd0;
`else
    localparam logic [7:0] EXP_NEG  = 8'h80;
    localparam logic [7:0] EXP_OVF  = 8'd127;
    localparam logic [7:0] EXP_BIAS = 8'hFB;
`endif

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A: CI=3, DUT B: CI=1
    logic             a_clr = 1'b0, a_valid = 1'b0;
    logic [FM_W-1:0]  a_fmap = '0;
    logic [WT_W-1:0]  a_wt = '0;
    logic [15:0]      a_bias = '0;
    logic             a_busy, a_ot_valid;
    logic [7:0]       a_res;

    logic             b_clr = 1'b0, b_valid = 1'b0;
    logic [FM_W-1:0]  b_fmap = '0;
    logic [WT_W-1:0]  b_wt = '0;
    logic [15:0]      b_bias = '0;
    logic             b_busy, b_ot_valid;
    logic [7:0]       b_res;

    cnn_kernel_mc #(.KX(5), .KY(5), .CI(3), .I_F_BW(8), .W_BW(8), .B_BW(16), .O_BW(8)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .i_clr(a_clr), .i_in_valid(a_valid),
        .i_in_fmap(a_fmap), .i_cnn_weight(a_wt), .i_cnn_bias(a_bias),
        .o_busy(a_busy), .o_ot_valid(a_ot_valid), .o_ot_result(a_res)
    );

    cnn_kernel_mc #(.KX(5), .KY(5), .CI(1), .I_F_BW(8), .W_BW(8), .B_BW(16), .O_BW(8)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .i_clr(b_clr), .i_in_valid(b_valid),
        .i_in_fmap(b_fmap), .i_cnn_weight(b_wt), .i_cnn_bias(b_bias),
        .o_busy(b_busy), .o_ot_valid(b_ot_valid), .o_ot_result(b_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FM_W-1:0] rep_pix(input int p);
        logic [FM_W-1:0] v;
        for (int n = 0; n < N; n++) v[n*8 +: 8] = 8'(p);
        return v;
    endfunction

    function automatic logic [WT_W-1:0] rep_wt(input int w);
        logic [WT_W-1:0] v;
        for (int n = 0; n < N; n++) v[n*8 +: 8] = 8'(w);
        return v;
    endfunction

    // pixel[n]=n, weight[n]=+1 for even n, -1 for odd n -> window sum 12
    function automatic logic [FM_W-1:0] pat_pix();
        logic [FM_W-1:0] v;
        for (int n = 0; n < N; n++) v[n*8 +: 8] = 8'(n);
        return v;
    endfunction

    function automatic logic [WT_W-1:0] pat_wt();
        logic [WT_W-1:0] v;
        for (int n = 0; n < N; n++) v[n*8 +: 8] = (n % 2 == 1) ? 8'hFF : 8'h01;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Sets DUT A inputs at a falling edge; the beat is sampled on the next
    // rising edge, so its strobe is visible 5 negedges later in cyc terms.
    task automatic drive_a(input logic v, input logic c, input logic [FM_W-1:0] f,
                           input logic [WT_W-1:0] w, input int b,
                           input bit push, input logic [7:0] ev);
        @(negedge clk);
        a_valid = v; a_clr = c; a_fmap = f; a_wt = w; a_bias = 16'(b);
        if (push) q_a.push_back('{ev, cyc + 5});
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_valid = 1'b0; a_clr = 1'b0;
        end
    endtask

    // Scoreboard monitors: compare every strobe against the queue head.
    always @(negedge clk) begin
        if (reset_n && a_ot_valid) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL strobe_a unexpected result=%0d cycle=%0d required=no strobe", $signed(a_res), cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (a_res !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe_a result=%0d cycle=%0d required result=%0d cycle=%0d",
                             $signed(a_res), cyc, $signed(e.val), e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && b_ot_valid) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL strobe_b unexpected result=%0d cycle=%0d required=no strobe", $signed(b_res), cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (b_res !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe_b result=%0d cycle=%0d required result=%0d cycle=%0d",
                             $signed(b_res), cyc, $signed(e.val), e.cyc);
                end
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", int'(a_ot_valid), 0);
        chk("rst_a_result", int'(a_res), 0);
        chk("rst_a_busy", int'(a_busy), 0);
        chk("rst_b_valid", int'(b_ot_valid), 0);
        reset_n = 1'b1;
        idle_a(2);

        // ---------------- ones, with a gap inside the group ----------------
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        idle_a(1);
        chk("ones_busy_mid", int'(a_busy), 1);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 1, 8'd75);
        idle_a(1);
        chk("ones_busy_after_last", int'(a_busy), 0);
        idle_a(6);

        // ---------------- negative sum ----------------
        drive_a(1, 0, rep_pix(10), rep_wt(-1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(10), rep_wt(-1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(10), rep_wt(-1), 0, 1, EXP_NEG);
        idle_a(6);

        // ---------------- overflow ----------------
        drive_a(1, 0, rep_pix(255), rep_wt(127), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(255), rep_wt(127), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(255), rep_wt(127), 0, 1, EXP_OVF);
        idle_a(6);

        // ---------------- bias, back-to-back groups ----------------
        // Non-last beats carry a junk bias that must be ignored.
        drive_a(1, 0, rep_pix(1), rep_wt(1), 999, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 999, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), -80, 1, EXP_BIAS);
        drive_a(1, 0, rep_pix(1), rep_wt(1), -999, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), -999, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 20, 1, 8'd95);
        idle_a(6);

        // ---------------- element indexing pattern ----------------
        drive_a(1, 0, pat_pix(), pat_wt(), 0, 0, 8'd0);
        drive_a(1, 0, pat_pix(), pat_wt(), 0, 0, 8'd0);
        drive_a(1, 0, pat_pix(), pat_wt(), 10, 1, 8'd46);
        idle_a(6);

        // ---------------- abort ----------------
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        chk("abort_busy_b1", int'(a_busy), 1);
        drive_a(1, 1, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        chk("abort_busy_b2", int'(a_busy), 1);
        idle_a(1);
        chk("abort_busy_clr", int'(a_busy), 0);
        chk("abort_valid_clr", int'(a_ot_valid), 0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 0, 8'd0);
        drive_a(1, 0, rep_pix(1), rep_wt(1), 0, 1, 8'd75);
        idle_a(8);

        // ---------------- reset mid-stream, CI=1 ----------------
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_valid = 1'b1; a_fmap = rep_pix(1); a_wt = rep_wt(1); a_bias = '0;
            b_valid = 1'b1; b_fmap = rep_pix(2); b_wt = rep_wt(1); b_bias = '0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("midrst_a_valid", int'(a_ot_valid), 0);
        chk("midrst_a_result", int'(a_res), 0);
        chk("midrst_a_busy", int'(a_busy), 0);
        chk("midrst_b_valid", int'(b_ot_valid), 0);
        chk("midrst_b_result", int'(b_res), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) chk("ci1_busy", int'(b_busy), 0);
            b_valid = 1'b1; b_fmap = rep_pix(k + 1); b_wt = rep_wt(1);
            b_bias = 16'(k);
            q_b.push_back('{8'(25 * (k + 1) + k), cyc + 5});
            a_valid = (k < 3); a_fmap = rep_pix(1); a_wt = rep_wt(1); a_bias = '0;
            if (k == 2) q_a.push_back('{8'd75, cyc + 5});
        end
        @(negedge clk);
        chk("ci1_busy", int'(b_busy), 0);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("ci1_busy_tail", int'(b_busy), 0);
        end
        idle_a(6);

        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
